// File: rtl/hdmi_pic_pkg.sv
// hdmi_pic_pkg: shared types and defaults for the picture fetch path.
// Holds the pixel type, window geometry and the ROM read latency.
package hdmi_pic_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 24;
  localparam int POS_W   = 12;

  localparam int IMG_W   = 256;
  localparam int IMG_H   = 256;
  localparam int X0      = 512;
  localparam int Y0      = 232;

  // Address latch plus output register inside the ROM wrapper.
  localparam int ROM_LAT = 2;

  typedef logic [23:0] rgb_t;

  localparam rgb_t BG_COLOR = 24'h000000;

  // Sideband carried alongside the ROM read.
  typedef struct packed {
    logic win;
    logic de;
    logic hs;
    logic vs;
  } vid_ctl_t;

endpackage

// File: rtl/hdmi_pic_fetch_if.sv
// hdmi_pic_fetch_if: timing-in, ROM and encoder-out bundle.
// slave = fetch block view, master = timing gen / ROM / encoder view.
interface hdmi_pic_fetch_if #(
  parameter int ADDR_W = hdmi_pic_pkg::ADDR_W,
  parameter int DATA_W = hdmi_pic_pkg::DATA_W,
  parameter int POS_W  = hdmi_pic_pkg::POS_W
) ();

  logic [POS_W-1:0]  pix_x;
  logic [POS_W-1:0]  pix_y;
  logic              de_in;
  logic              hs_in;
  logic              vs_in;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] rgb_out;
  logic              de_out;
  logic              hs_out;
  logic              vs_out;
  logic              frame_done;

  modport slave (
    input  pix_x,
    input  pix_y,
    input  de_in,
    input  hs_in,
    input  vs_in,
    input  rom_data,
    output rom_addr,
    output rgb_out,
    output de_out,
    output hs_out,
    output vs_out,
    output frame_done
  );

  modport master (
    output pix_x,
    output pix_y,
    output de_in,
    output hs_in,
    output vs_in,
    output rom_data,
    input  rom_addr,
    input  rgb_out,
    input  de_out,
    input  hs_out,
    input  vs_out,
    input  frame_done
  );

endinterface

// File: rtl/sig_delay_line.sv
// sig_delay_line: DEPTH-stage shift register, async reset to 0.
// Ports: clk, rst, d_i (WIDTH) in, q_o (WIDTH) = d_i delayed DEPTH clocks.
module sig_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/hdmi_pic_fetch.sv
// hdmi_pic_fetch: addresses the picture ROM inside a fixed window and
// realigns de/hs/vs to the ROM latency (3 clocks input to output).
// Ports: clk, rst (async, high); bus (slave): pix_x/pix_y/de/hs/vs in,
// rom_addr/rom_data, rgb_out/de_out/hs_out/vs_out, frame_done out.
module hdmi_pic_fetch #(
  parameter int   ADDR_W   = hdmi_pic_pkg::ADDR_W,
  parameter int   DATA_W   = hdmi_pic_pkg::DATA_W,
  parameter int   POS_W    = hdmi_pic_pkg::POS_W,
  parameter int   IMG_W    = hdmi_pic_pkg::IMG_W,
  parameter int   IMG_H    = hdmi_pic_pkg::IMG_H,
  parameter int   X0       = hdmi_pic_pkg::X0,
  parameter int   Y0       = hdmi_pic_pkg::Y0,
  parameter int   ROM_LAT  = hdmi_pic_pkg::ROM_LAT,
  parameter logic [DATA_W-1:0] BG_COLOR = hdmi_pic_pkg::BG_COLOR,
  parameter logic VS_ACT   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  hdmi_pic_fetch_if.slave bus
);

  import hdmi_pic_pkg::vid_ctl_t;

  localparam int PW = POS_W + 1;

  // One extra bit so X0+IMG_W / Y0+IMG_H cannot wrap.
  localparam logic [POS_W:0] X_LO = PW'(X0);
  localparam logic [POS_W:0] X_HI = PW'(X0 + IMG_W);
  localparam logic [POS_W:0] Y_LO = PW'(Y0);
  localparam logic [POS_W:0] Y_HI = PW'(Y0 + IMG_H);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(IMG_W * IMG_H - 1);

  logic [POS_W:0]    px;
  logic [POS_W:0]    py;
  logic              in_win;
  logic              frame_start;
  logic              vs_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              done_q;
  logic              done_d;

  assign px = {1'b0, bus.pix_x};
  assign py = {1'b0, bus.pix_y};

  assign in_win = bus.de_in
                & (px >= X_LO) & (px < X_HI)
                & (py >= Y_LO) & (py < Y_HI);

  // Edge of vs into its active level, against last cycle's vs.
  assign frame_start = (bus.vs_in == VS_ACT)
                     & (vs_q != VS_ACT);

  always_comb begin
    addr_d = addr_q;
    done_d = 1'b0;
    if (frame_start) begin
      addr_d = '0;
    end else if (in_win) begin
      if (addr_q == LAST) begin
        addr_d = '0;
        done_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q   <= 1'b0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      vs_q   <= bus.vs_in;
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end

  assign bus.rom_addr   = addr_q;
  assign bus.frame_done = done_q;

  vid_ctl_t ctl_in;
  vid_ctl_t ctl_dly;

  assign ctl_in = '{
    win: in_win,
    de:  bus.de_in,
    hs:  bus.hs_in,
    vs:  bus.vs_in
  };

  sig_delay_line #(
    .WIDTH ($bits(vid_ctl_t)),
    .DEPTH (ROM_LAT)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .d_i (ctl_in),
    .q_o (ctl_dly)
  );

  logic [DATA_W-1:0] rgb_q;
  logic              de_q;
  logic              hs_q;
  logic              vs_o_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q  <= '0;
      de_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_o_q <= 1'b0;
    end else begin
      rgb_q  <= ctl_dly.win ? bus.rom_data : BG_COLOR;
      de_q   <= ctl_dly.de;
      hs_q   <= ctl_dly.hs;
      vs_o_q <= ctl_dly.vs;
    end
  end

  assign bus.rgb_out = rgb_q;
  assign bus.de_out  = de_q;
  assign bus.hs_out  = hs_q;
  assign bus.vs_out  = vs_o_q;

endmodule

// File: tb/tb_hdmi_pic_fetch.sv
// tb_hdmi_pic_fetch: directed + random stimulus against a pixel-level
// reference model (window rule, linear address, 3-clock latency queue).
module tb_hdmi_pic_fetch;

  import hdmi_pic_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hdmi_pic_fetch_if bus ();

  hdmi_pic_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model: data = address, address latch then output register.
  logic [15:0] rom_a_q;
  always @(posedge clk) begin
    rom_a_q      <= bus.rom_addr;
    bus.rom_data <= {8'h00, rom_a_q};
  end

  typedef struct {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    int          tag;
  } exp_t;

  exp_t        q[$];
  int unsigned m_cnt;
  logic        m_vs;
  logic        m_fd;
  int          passed = 0;
  int          total  = 0;
  int          fd_seen;

  task automatic check(input string name,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                name, obs, exp);
  endtask

  function automatic logic [23:0] tag_rgb(input int t);
    case (t)
      1:       return 24'h000000;
      2:       return 24'h000001;
      3:       return 24'h000100;
      4:       return 24'h00FFFF;
      default: return BG_COLOR;
    endcase
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{rgb: 24'h0, de: 1'b0, hs: 1'b0, vs: 1'b0, tag: 0};
    q.delete();
    repeat (3) q.push_back(z);
    m_cnt = 0;
    m_vs  = 1'b0;
    m_fd  = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_rgb"}, 32'(bus.rgb_out), 32'h0);
    check({name, "_ctl"},
          32'({bus.de_out, bus.hs_out, bus.vs_out}), 32'h0);
    check({name, "_addr"}, 32'(bus.rom_addr), 32'h0);
    check({name, "_fd"}, 32'(bus.frame_done), 32'h0);
  endtask

  // One pixel clock: drive inputs, predict, clock, compare.
  task automatic step(input int x, input int y,
                      input logic de, input logic hs,
                      input logic vs, input int tag);
    exp_t e;
    logic win;
    logic fs;
    bus.pix_x = 12'(x);
    bus.pix_y = 12'(y);
    bus.de_in = de;
    bus.hs_in = hs;
    bus.vs_in = vs;
    win = de && x >= X0 && x < X0 + IMG_W
             && y >= Y0 && y < Y0 + IMG_H;
    fs   = vs && !m_vs;
    m_vs = vs;
    e.rgb = win ? 24'(m_cnt) : BG_COLOR;
    e.de  = de;
    e.hs  = hs;
    e.vs  = vs;
    e.tag = tag;
    q.push_back(e);
    m_fd = win && !fs && (m_cnt == NPIX - 1);
    if (fs) m_cnt = 0;
    else if (win) m_cnt = (m_cnt + 1) % NPIX;
    @(posedge clk);
    #1;
    void'(q.pop_front());
    check("rgb", 32'(bus.rgb_out), 32'(q[0].rgb));
    check("ctl", 32'({bus.de_out, bus.hs_out, bus.vs_out}),
          32'({q[0].de, q[0].hs, q[0].vs}));
    check("rom_addr", 32'(bus.rom_addr), m_cnt);
    check("frame_done", 32'(bus.frame_done), 32'(m_fd));
    if (q[0].tag != 0)
      check($sformatf("point%0d", q[0].tag),
            32'(bus.rgb_out), 32'(tag_rgb(q[0].tag)));
    if (bus.frame_done === 1'b1) fd_seen++;
  endtask

  task automatic blank();
    step(int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)),
         1'b0, 1'($urandom_range(0, 1)), 1'b0, 0);
  endtask

  task automatic vsync();
    step(0, 0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) step(0, 0, 1'b0, 1'b0, 1'b1, 0);
    repeat (2) step(0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic row(input int y, input int xa, input int xb);
    for (int x = xa; x <= xb; x++) begin
      int t;
      t = 0;
      if (y == 232 && x == 512) t = 1;
      if (y == 232 && x == 513) t = 2;
      if (y == 233 && x == 512) t = 3;
      if (y == 487 && x == 767) t = 4;
      step(x, y, 1'b1, 1'b0, 1'b0, t);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.pix_x = '0;
    bus.pix_y = '0;
    bus.de_in = 1'b0;
    bus.hs_in = 1'b0;
    bus.vs_in = 1'b0;
    model_reset();

    // Reset with random inputs.
    for (int i = 0; i < 5; i++) begin
      bus.pix_x = 12'($urandom_range(0, 4095));
      bus.pix_y = 12'($urandom_range(0, 4095));
      bus.de_in = 1'($urandom_range(0, 1));
      bus.hs_in = 1'($urandom_range(0, 1));
      bus.vs_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_zero("reset");
    end
    rst = 1'b0;
    model_reset();

    // Random positions around the window, random syncs.
    for (int i = 0; i < 2000; i++) begin
      step(int'($urandom_range(500, 780)),
           int'($urandom_range(225, 495)),
           $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 99) == 0, 0);
    end

    // Full frame with edge pixels on the first row.
    vsync();
    fd_seen = 0;
    for (int y = Y0; y < Y0 + IMG_H; y++) begin
      if (y == Y0) begin
        step(X0 - 1, y, 1'b1, 1'b0, 1'b0, 5);
        check("addr_left_edge", 32'(bus.rom_addr), 32'd0);
      end
      row(y, X0, X0 + IMG_W - 1);
      if (y == Y0) begin
        step(X0 + IMG_W, y, 1'b1, 1'b0, 1'b0, 6);
        check("addr_right_edge", 32'(bus.rom_addr), 32'd256);
      end
      blank();
    end
    repeat (3) blank();
    check("frame_done_count", 32'(fd_seen), 32'd1);
    check("addr_after_frame", 32'(bus.rom_addr), 32'd0);

    // Second frame restarts at 0; vs edge during in_win.
    vsync();
    row(232, 512, 519);
    step(520, 232, 1'b1, 1'b0, 1'b1, 0);
    check("fs_win_addr", 32'(bus.rom_addr), 32'd0);
    step(521, 232, 1'b1, 1'b0, 1'b1, 0);
    check("after_fs_addr", 32'(bus.rom_addr), 32'd1);
    repeat (3) blank();

    // Mid-frame reset at address 1000.
    vsync();
    for (int y = 232; y < 235; y++) begin
      row(y, 512, 767);
      blank();
    end
    row(235, 512, 743);
    check("addr_1000", 32'(bus.rom_addr), 32'd1000);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midreset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("midreset_hold");
    end
    rst = 1'b0;
    model_reset();
    row(235, 744, 767);
    blank();
    vsync();
    row(232, 512, 515);
    repeat (4) blank();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
